// File: rtl/dmem_responder.sv
// Data RAM plus GPIO latch and optional compare/match timer for the single-cycle core.
// Define DMEM_TIMER_EN to build the TCOUNT/TCMP/TSTAT/TCTRL timer and irq.
module dmem_responder #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0000_8000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] daddr,
  input  logic [31:0] din,
  input  logic        MemWrite,
  output logic [31:0] dout,
  output logic [31:0] gpio_out,
  output logic        irq,
  output logic        bad_addr
);

  localparam int          AW = $clog2(DEPTH);
  localparam logic [29:0] MB = MMIO_BASE[31:2];

  logic [31:0]   r_ram [DEPTH];
  logic [31:0]   r_gpio;
  logic          r_bad;
  logic [29:0]   w_word;
  logic [AW-1:0] w_idx;
  logic          w_ram;
  logic          w_gpio;
  logic          w_mapped;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_word   = daddr[31:2];
  assign w_idx    = daddr[AW+1:2];
  assign w_ram    = (daddr[31:AW+2] == '0);
  assign w_gpio   = (w_word == MB);
  assign w_unused = ^daddr[1:0];

`ifdef DMEM_TIMER_EN
  logic [31:0] r_tcount;
  logic [31:0] r_tcmp;
  logic [1:0]  r_tctrl;
  logic        r_match;
  logic        w_tcnt;
  logic        w_tcmp;
  logic        w_tstat;
  logic        w_tctl;
  logic        w_hit;

  assign w_tcnt   = (w_word == MB + 30'd1);
  assign w_tcmp   = (w_word == MB + 30'd2);
  assign w_tstat  = (w_word == MB + 30'd3);
  assign w_tctl   = (w_word == MB + 30'd4);
  assign w_mapped = w_ram | w_gpio | w_tcnt
                  | w_tcmp | w_tstat | w_tctl;
  // compare uses the pre-edge TCMP, so a TCMP write lands next cycle
  assign w_hit    = r_tctrl[0] && (r_tcount == r_tcmp);
  assign irq      = r_match;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_tcount <= '0;
      r_tcmp   <= '1;
      r_tctrl  <= '0;
      r_match  <= 1'b0;
    end else begin
      if (MemWrite && w_tcnt)
        r_tcount <= din;
      else if (r_tctrl[0])
        r_tcount <= (w_hit && r_tctrl[1]) ? '0
                                          : r_tcount + 32'd1;
      if (MemWrite && w_tcmp)
        r_tcmp <= din;
      if (MemWrite && w_tctl)
        r_tctrl <= din[1:0];
      if (w_hit)
        r_match <= 1'b1;
      else if (MemWrite && w_tstat && din[0])
        r_match <= 1'b0;
    end
  end
`else
  assign w_mapped = w_ram | w_gpio;
  assign irq      = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_ram:   w_rdata = r_ram[w_idx];
      w_gpio:  w_rdata = r_gpio;
`ifdef DMEM_TIMER_EN
      w_tcnt:  w_rdata = r_tcount;
      w_tcmp:  w_rdata = r_tcmp;
      w_tstat: w_rdata = {31'b0, r_match};
      w_tctl:  w_rdata = {30'b0, r_tctrl};
`endif
      default: w_rdata = '0;
    endcase
  end

  assign dout     = w_rdata;
  assign gpio_out = r_gpio;
  assign bad_addr = r_bad;

  // RAM is not reset, but writes during reset are still discarded
  always_ff @(posedge sys_clk) begin
    if (sys_rst_n && MemWrite && w_ram)
      r_ram[w_idx] <= din;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_gpio <= '0;
      r_bad  <= 1'b0;
    end else begin
      if (MemWrite && w_gpio)
        r_gpio <= din;
      if (!w_mapped)
        r_bad <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: abstract memory-map model checked every cycle,
// plus hand-computed expectations along the test plan.
module tb_dmem_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] MMIO  = 32'h0000_8000;
  localparam int          AW    = $clog2(DEPTH);

  localparam logic [31:0] A_GPIO = MMIO;
  localparam logic [31:0] A_TCNT = MMIO + 32'h4;
  localparam logic [31:0] A_TCMP = MMIO + 32'h8;
  localparam logic [31:0] A_TSTA = MMIO + 32'hC;
  localparam logic [31:0] A_TCTL = MMIO + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] daddr = MMIO;
  logic [31:0] din = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] dout;
  logic [31:0] gpio_out;
  logic        irq;
  logic        bad_addr;

  int nvec = 0;
  int nerr = 0;

  dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO)) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .daddr(daddr),
    .din(din),
    .MemWrite(MemWrite),
    .dout(dout),
    .gpio_out(gpio_out),
    .irq(irq),
    .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  // model state
  bit          m_valid = 1'b0;
  logic [31:0] m_ram [int];
  logic [31:0] m_gpio, m_cnt, m_cmp;
  logic [1:0]  m_ctl;
  logic        m_match, m_bad;

  // 0 ram, 1 gpio, 2 tcount, 3 tcmp, 4 tstat, 5 tctrl, -1 unmapped
  function automatic int region(input logic [31:0] a);
    if (a < DEPTH * 4) return 0;
    if (a[31:2] == A_GPIO[31:2]) return 1;
`ifdef DMEM_TIMER_EN
    if (a[31:2] == A_TCNT[31:2]) return 2;
    if (a[31:2] == A_TCMP[31:2]) return 3;
    if (a[31:2] == A_TSTA[31:2]) return 4;
    if (a[31:2] == A_TCTL[31:2]) return 5;
`endif
    return -1;
  endfunction

  // {known, value}
  function automatic logic [32:0] mread(input logic [31:0] a);
    int idx;
    idx = int'(a[AW+1:2]);
    case (region(a))
      0: return m_ram.exists(idx) ? {1'b1, m_ram[idx]} : 33'h0;
      1: return {1'b1, m_gpio};
      2: return {1'b1, m_cnt};
      3: return {1'b1, m_cmp};
      4: return {1'b1, 31'b0, m_match};
      5: return {1'b1, 30'b0, m_ctl};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h @%0t", n, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int          rg;
    bit          hit;
    logic [31:0] n_cnt;
    logic        n_match;
    if (!rst_n) begin
      m_gpio  = '0;
      m_bad   = 1'b0;
      m_cnt   = '0;
      m_cmp   = '1;
      m_ctl   = '0;
      m_match = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      rg      = region(daddr);
      hit     = m_ctl[0] && (m_cnt == m_cmp);
      n_cnt   = m_cnt;
      if (m_ctl[0]) n_cnt = (hit && m_ctl[1]) ? 32'h0 : m_cnt + 32'd1;
      n_match = m_match;
      if (MemWrite && rg == 4 && din[0]) n_match = 1'b0;
      if (hit) n_match = 1'b1;
      if (MemWrite) begin
        case (rg)
          0: m_ram[int'(daddr[AW+1:2])] = din;
          1: m_gpio = din;
          2: n_cnt  = din;
          3: m_cmp  = din;
          5: m_ctl  = din[1:0];
          default: ;
        endcase
      end
      if (rg < 0) m_bad = 1'b1;
      m_cnt   = n_cnt;
      m_match = n_match;
    end
  end

  always @(negedge clk) begin
    logic [32:0] r;
    if (m_valid) begin
      r = mread(daddr);
      if (r[32]) chk("model_dout", dout, r[31:0]);
      chk("model_gpio", gpio_out, m_gpio);
      chk("model_irq", {31'b0, irq}, {31'b0, m_match});
      chk("model_bad", {31'b0, bad_addr}, {31'b0, m_bad});
    end
  end

  task automatic drive(input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic w);
    @(posedge clk);
    #2;
    rst_n = r;
    daddr = a;
    din = d;
    MemWrite = w;
  endtask

  task automatic settle;
    #4;
  endtask

  initial begin
    drive(1'b0, A_GPIO, 32'h0, 1'b0);
    settle;
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_bad", {31'b0, bad_addr}, 32'h0);
`ifdef DMEM_TIMER_EN
    drive(1'b0, A_TCMP, 32'h0, 1'b0);
    settle;
    chk("rst_tcmp", dout, 32'hFFFF_FFFF);
`endif

    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    settle;
    chk("ram_rd", dout, 32'hDEAD_BEEF);
    drive(1'b1, 32'h13, 32'h0, 1'b0);
    settle;
    chk("ram_rd_lowbits", dout, 32'hDEAD_BEEF);

    drive(1'b1, 32'h10, 32'h1, 1'b1);
    drive(1'b1, 32'h10, 32'h2, 1'b1);
    settle;
    chk("rbw_old", dout, 32'h1);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    settle;
    chk("rbw_new", dout, 32'h2);

    drive(1'b1, A_GPIO, 32'hA5, 1'b1);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    settle;
    chk("gpio_wr", gpio_out, 32'hA5);

    drive(1'b1, 32'h9000, 32'h1234, 1'b1);
    drive(1'b1, 32'h9000, 32'h0, 1'b0);
    settle;
    chk("unmap_bad", {31'b0, bad_addr}, 32'h1);
    chk("unmap_rd", dout, 32'h0);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    settle;
    chk("bad_sticky", {31'b0, bad_addr}, 32'h1);

`ifdef DMEM_TIMER_EN
    drive(1'b1, A_TCMP, 32'd5, 1'b1);
    drive(1'b1, A_TCTL, 32'd3, 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, A_TCNT, 32'h0, 1'b0);
      settle;
      chk("tcount_run", dout, k);
      chk("irq_pre", {31'b0, irq}, 32'h0);
    end
    drive(1'b1, A_TCNT, 32'h0, 1'b0);
    settle;
    chk("match_clr_cnt", dout, 32'h0);
    chk("match_irq", {31'b0, irq}, 32'h1);
    drive(1'b1, A_TSTA, 32'h1, 1'b1);
    drive(1'b1, A_TCNT, 32'h0, 1'b0);
    settle;
    chk("w1c_irq", {31'b0, irq}, 32'h0);
    chk("w1c_cnt", dout, 32'h2);
    drive(1'b1, A_TCNT, 32'h0, 1'b0);
    drive(1'b1, A_TCNT, 32'h0, 1'b0);
    drive(1'b1, A_TSTA, 32'h1, 1'b1);
    drive(1'b1, A_TCNT, 32'h0, 1'b0);
    settle;
    chk("w1c_vs_match", {31'b0, irq}, 32'h1);
    chk("w1c_vs_match_cnt", dout, 32'h0);

    drive(1'b1, A_TCNT, 32'h100, 1'b1);
    drive(1'b1, A_TCNT, 32'h0, 1'b0);
    settle;
    chk("coll_wr", dout, 32'h100);
    drive(1'b1, A_TCNT, 32'h0, 1'b0);
    settle;
    chk("coll_inc", dout, 32'h101);
    drive(1'b1, A_TSTA, 32'h1, 1'b1);
    drive(1'b1, A_TCMP, 32'h103, 1'b1);
    drive(1'b1, A_TCNT, 32'h0, 1'b0);
    settle;
    chk("tcmp_old_cmp", {31'b0, irq}, 32'h0);
    chk("tcmp_old_cnt", dout, 32'h104);
    drive(1'b1, A_TCTL, 32'h0, 1'b0);
    settle;
    chk("tctrl_rd", dout, 32'h3);
`endif

    drive(1'b0, 32'h10, 32'h9, 1'b1);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    settle;
    chk("rst_mid_gpio", gpio_out, 32'h0);
    chk("rst_mid_irq", {31'b0, irq}, 32'h0);
    chk("rst_mid_bad", {31'b0, bad_addr}, 32'h0);
    chk("rst_mid_ram", dout, 32'h2);
`ifdef DMEM_TIMER_EN
    drive(1'b1, A_TCNT, 32'h0, 1'b0);
    settle;
    chk("rst_mid_tcnt", dout, 32'h0);
`endif

    drive(1'b1, 32'h9004, 32'h0, 1'b0);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    settle;
    chk("unmap_read_bad", {31'b0, bad_addr}, 32'h1);

`ifndef DMEM_TIMER_EN
    drive(1'b1, A_TCNT, 32'h55, 1'b1);
    drive(1'b1, A_TCNT, 32'h0, 1'b0);
    settle;
    chk("notimer_rd", dout, 32'h0);
    chk("notimer_irq", {31'b0, irq}, 32'h0);
`endif

    drive(1'b1, 32'h3FC, 32'hCAFE_0001, 1'b1);
    drive(1'b1, 32'h3FC, 32'h0, 1'b0);
    settle;
    chk("ram_top", dout, 32'hCAFE_0001);
    drive(1'b1, 32'h400, 32'h0, 1'b0);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
